// File: rtl/gpr_pkg.sv
// Shared types and widths for the GPR writeback path: register geometry,
// writeback source identifiers and the registered write request.
package gpr_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/gpr_ld_scoreboard.sv
// Per-register outstanding-load counters. Gates load issue so that no
// counter can wrap, and publishes a registered busy flag per register.
module gpr_ld_scoreboard
  import gpr_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_issue_valid,
  output logic                ld_issue_ready,
  input  logic [ADDR_W-1:0]   ld_issue_dest,
  input  logic                mem_grant,
  input  logic [ADDR_W-1:0]   mem_dest,
  output logic [NUM_REGS-1:0] busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_REGS-1:0][CNT_W-1:0] r_cnt;
  logic [NUM_REGS-1:0][CNT_W-1:0] w_cnt_next;
  logic [NUM_REGS-1:0]            r_busy;
  logic [NUM_REGS-1:0]            w_up;
  logic [NUM_REGS-1:0]            w_dn;
  logic                           w_same_dec;
  logic                           w_inc;

  // A full counter may still accept an issue when a return to the same
  // register retires one load in the same cycle.
  assign w_same_dec     = mem_grant && (mem_dest == ld_issue_dest);
  assign ld_issue_ready = !rst && ((r_cnt[ld_issue_dest] != CNT_MAX) || w_same_dec);
  assign w_inc          = ld_issue_valid && ld_issue_ready;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cnt
      assign w_up[gi] = w_inc && (ld_issue_dest == ADDR_W'(gi));
      assign w_dn[gi] = mem_grant && (mem_dest == ADDR_W'(gi));
      // A return to an idle register is a protocol error and leaves it at 0.
      assign w_cnt_next[gi] =
        (w_up[gi] && !w_dn[gi])                        ? r_cnt[gi] + CNT_W'(1) :
        (w_dn[gi] && !w_up[gi] && (r_cnt[gi] != '0))   ? r_cnt[gi] - CNT_W'(1) :
                                                         r_cnt[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_busy <= '0;
    end else begin
      r_cnt <= w_cnt_next;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_busy[i] <= (w_cnt_next[i] != '0);
      end
    end
  end

  assign busy = r_busy;

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Two-source writeback arbiter (ALU / load return) for the GPR write port.
// Define GPR_WB_MEM_PRIO_EN for fixed load-return priority instead of round-robin.
module gpr_wb_arbiter
  import gpr_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [ADDR_W-1:0]   alu_dest,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [ADDR_W-1:0]   mem_dest,
  input  logic [DATA_W-1:0]   mem_data,
  input  logic                ld_issue_valid,
  output logic                ld_issue_ready,
  input  logic [ADDR_W-1:0]   ld_issue_dest,
  output logic                gpr_write_en,
  output logic [ADDR_W-1:0]   gpr_write_dest,
  output logic [DATA_W-1:0]   gpr_write_data,
  output logic [NUM_REGS-1:0] busy
);

  logic    w_alu_gnt;
  logic    w_mem_gnt;
  logic    r_wr_en;
  wb_req_t r_wr;

`ifndef GPR_WB_MEM_PRIO_EN
  wb_src_e r_last_grant;
`endif

  // Nothing is accepted while reset is held, so no write can leak past it.
  always_comb begin
    w_alu_gnt = 1'b0;
    w_mem_gnt = 1'b0;
    if (!rst) begin
`ifdef GPR_WB_MEM_PRIO_EN
      w_mem_gnt = mem_valid;
      w_alu_gnt = alu_valid && !mem_valid;
`else
      if (alu_valid && mem_valid) begin
        w_alu_gnt = (r_last_grant == WB_SRC_MEM);
        w_mem_gnt = (r_last_grant == WB_SRC_ALU);
      end else begin
        w_alu_gnt = alu_valid;
        w_mem_gnt = mem_valid;
      end
`endif
    end
  end

  assign alu_ready = w_alu_gnt;
  assign mem_ready = w_mem_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en <= 1'b0;
      r_wr    <= '0;
    end else begin
      r_wr_en <= w_alu_gnt || w_mem_gnt;
      if (w_alu_gnt) begin
        r_wr <= '{dest: alu_dest, data: alu_data};
      end else if (w_mem_gnt) begin
        r_wr <= '{dest: mem_dest, data: mem_data};
      end
    end
  end

`ifndef GPR_WB_MEM_PRIO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= WB_SRC_MEM;
    end else if (w_alu_gnt) begin
      r_last_grant <= WB_SRC_ALU;
    end else if (w_mem_gnt) begin
      r_last_grant <= WB_SRC_MEM;
    end
  end
`endif

  // Gating with rst drops a write that was registered just before reset.
  assign gpr_write_en   = r_wr_en && !rst;
  assign gpr_write_dest = r_wr.dest;
  assign gpr_write_data = r_wr.data;

  gpr_ld_scoreboard #(
    .CNT_W (CNT_W)
  ) u_ld_scoreboard (
    .clk            (clk),
    .rst            (rst),
    .ld_issue_valid (ld_issue_valid),
    .ld_issue_ready (ld_issue_ready),
    .ld_issue_dest  (ld_issue_dest),
    .mem_grant      (w_mem_gnt),
    .mem_dest       (mem_dest),
    .busy           (busy)
  );

endmodule
